// File: rtl/demux_stream_pkg.sv
// demux_stream shared types: holding-register state and stat counter width.
// Imported by the demux_stream top and its sat_counter sub-module.
package demux_stream_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/demux_stream_if.sv
// demux_stream bus: upstream valid/ready word plus per-channel outputs.
// master drives the word and downstream readies; slave is the demux.
interface demux_stream_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic [SELW-1:0]           in_sel;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic                      drop_pulse;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, drop_pulse
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, drop_pulse
  );

endinterface

// File: rtl/demux_stream_sat_counter.sv
// sat_counter: saturating up-counter, one per demux_stream channel.
// Only instantiated when DEMUX_STREAM_STATS_EN is defined.
module sat_counter
  import demux_stream_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/demux_stream.sv
// demux_stream: single-entry 1-to-N stream demultiplexer, no-bubble refill.
// DEMUX_STREAM_STATS_EN adds per-channel saturating transfer counters.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic clk,
  input  logic rst_n,
  demux_stream_if.slave bus
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [CHANNELS*STAT_W-1:0] stat_count
`endif
);

  localparam int SELW = $clog2(CHANNELS);
  localparam logic [SELW:0] CH_LIM = (SELW+1)'(CHANNELS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             drop_q, drop_d;
  logic             full, in_fire, out_fire, sel_ok;

  assign full     = (state_q == FULL);
  assign out_fire = full & bus.out_ready[sel_q];
  // Refill is allowed only when the held word leaves this cycle.
  assign bus.in_ready = rst_n & (~full | bus.out_ready[sel_q]);
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign sel_ok   = ({1'b0, bus.in_sel} < CH_LIM);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    drop_d  = 1'b0;
    if (out_fire) state_d = EMPTY;
    if (in_fire) begin
      if (sel_ok) begin
        state_d = FULL;
        data_d  = bus.in_data;
        sel_d   = bus.in_sel;
      end else begin
        drop_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.drop_pulse = drop_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic hit;
    assign hit = full & (sel_q == SELW'(k));
    assign bus.out_valid[k] = hit;
    assign bus.out_data[k*WIDTH +: WIDTH] = hit ? data_q : '0;
`ifdef DEMUX_STREAM_STATS_EN
    sat_counter #(.W(STAT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit & bus.out_ready[k]),
      .count (stat_count[k*STAT_W +: STAT_W])
    );
`endif
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL be >= 1.
REQ-002 Parameter CHANNELS, default 4, output channel count; SHALL be >= 2.
REQ-003 Localparam SELW = $clog2(CHANNELS), select width; not overridable.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  upstream data valid.
REQ-007 in_ready  output  1  block accepts the upstream word this cycle.
REQ-008 in_data  input  WIDTH  upstream data word.
REQ-009 in_sel  input  SELW  destination channel, sampled with in_data.
REQ-010 out_valid  output  CHANNELS  per-channel valid; bit k belongs to channel k.
REQ-011 out_ready  input  CHANNELS  per-channel downstream ready.
REQ-012 out_data  output  CHANNELS*WIDTH  flattened per-channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 drop_pulse  output  1  one-cycle pulse when an out-of-range word is discarded.

Function
REQ-014 The block SHALL hold a single-entry register (data, sel) with two states: EMPTY and FULL.
REQ-015 An input transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-016 An output transfer occurs when out_valid[k] and out_ready[k] are both 1 on a rising edge.
REQ-017 EMPTY: in_ready = 1; a transfer with in_sel < CHANNELS SHALL capture data/sel and move to FULL.
REQ-018 FULL: out_valid[held_sel] = 1; all other out_valid bits SHALL be 0.
REQ-019 FULL: in_ready = out_ready[held_sel]; a simultaneous input and output transfer SHALL replace the entry and stay in FULL (no bubble).
REQ-020 FULL: an output transfer with no input transfer SHALL move to EMPTY.
REQ-021 Latency SHALL be one cycle, in_data to out_data; sustained throughput SHALL be one word per cycle when the target channel is ready.
REQ-022 out_data of any channel whose out_valid bit is 0 SHALL be all zeros.
REQ-023 An input transfer with in_sel >= CHANNELS SHALL be accepted with the normal in_ready rule and discarded; the state is unchanged except for any simultaneous output transfer.
REQ-024 On such a discard, drop_pulse SHALL be 1 for exactly the following cycle.
REQ-025 out_valid SHALL NOT deassert, and held data SHALL NOT change, while FULL and out_ready[held_sel] = 0.
REQ-026 out_ready bits of non-selected channels SHALL have no effect.

Reset
REQ-027 When rst_n = 0 at a rising edge, the state SHALL become EMPTY, out_valid = 0, out_data = 0 and drop_pulse = 0.
REQ-028 During reset in_ready SHALL be 0; any held word SHALL be discarded and not presented after reset.
REQ-029 in_ready SHALL be 1 from the first cycle after rst_n returns to 1.

Configuration
REQ-030 Macro DEMUX_STREAM_STATS_EN SHALL, when defined, add output stat_count (CHANNELS*16 bits): one 16-bit saturating counter per channel, incremented on each output transfer of that channel and cleared by reset.
REQ-031 When DEMUX_STREAM_STATS_EN is undefined, stat_count and its counters SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Shared package demux_stream_pkg SHALL hold the state enum (EMPTY, FULL) and the stat counter width constant (16).
REQ-033 Stat counters SHALL be one sub-module, sat_counter, instantiated once per channel under the macro.

Verification
REQ-034 Reset with in_valid = 1: out_valid = 0000 and in_ready = 0 during reset; in_ready = 1 in the first cycle after release.
REQ-035 WIDTH = 8, CHANNELS = 4, all ready: send 0x11/sel0, 0x22/sel1, 0x33/sel2, 0x44/sel3 back-to-back -> out_valid one-hot 0001, 0010, 0100, 1000 on consecutive cycles with matching data; other lanes 0.
REQ-036 out_ready[2] = 0, send 0xA5/sel2, then 0x5A/sel0 -> in_ready = 0, out_data lane 2 holds 0xA5 stable; after ready is raised, 0x5A appears on lane 0 the next cycle.
REQ-037 CHANNELS = 3, send 0x77/sel3 -> no out_valid, drop_pulse = 1 for exactly one cycle.
REQ-038 Assert reset while FULL with 0x9C on lane 1 and out_ready = 0 -> after release out_valid = 000 and 0x9C is never delivered.
REQ-039 With DEMUX_STREAM_STATS_EN: 70000 transfers to channel 0 -> stat_count lane 0 = 0xFFFF, other lanes 0.
